// File: rtl/psum_quant_pkg.sv
// psum_quant_pkg: shared widths, packed activation type and pooling helper
package psum_quant_pkg;
  localparam int PSUM_W = 20;
  localparam int BIAS_W = 16;
  localparam int ACT_W = 8;
  localparam int ACT_MAX = 127;
  localparam int LANES = 4;
  typedef logic [LANES-1:0][ACT_W-1:0] act_vec_t;
  function automatic logic [ACT_W-1:0] max4(input act_vec_t a);
    logic [ACT_W-1:0] m;
    m = a[0];
    for (int i = 1; i < LANES; i++) m = (a[i] > m) ? a[i] : m;
    return m;
  endfunction
endpackage

// File: rtl/quant_lane.sv
// quant_lane: ReLU, round-half-up arithmetic right shift and int8 saturation
module quant_lane
  import psum_quant_pkg::*;
#(
  parameter int W = 29
) (
  input  logic signed [W-1:0] s1,
  input  logic [4:0]          shift,
  output logic [ACT_W-1:0]    act
);
  localparam logic [W:0] MAXV = (W+1)'(ACT_MAX);
  logic [W:0] r, rnd, q;
  always_comb begin
    r = s1[W-1] ? '0 : {2'b00, s1[W-2:0]};
    rnd = (shift == 5'd0) ? '0 : ({{W{1'b0}}, 1'b1} << (shift - 5'd1));
    q = (r + rnd) >> shift;
    act = (q > MAXV) ? ACT_W'(ACT_MAX) : q[ACT_W-1:0];
  end
endmodule

// File: rtl/psum_quant.sv
// psum_quant: accumulate MAC partial sums over channels, bias, quantize to int8, 2x2 max-pool
module psum_quant
  import psum_quant_pkg::*;
#(
  parameter int ACC_W = 28,
  parameter int CH_W = 8
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     vld_i,
  input  logic signed [PSUM_W-1:0] iPsum0,
  input  logic signed [PSUM_W-1:0] iPsum1,
  input  logic signed [PSUM_W-1:0] iPsum2,
  input  logic signed [PSUM_W-1:0] iPsum3,
  input  logic [CH_W-1:0]          iNumCh,
  input  logic signed [BIAS_W-1:0] iBias,
  input  logic [4:0]               iShift,
  input  logic                     iClr,
  output act_vec_t                 oOut,
  output logic [ACT_W-1:0]         oPool,
  output logic                     vld_o
);
  logic [CH_W-1:0] cnt, cnt_eff, last_idx;
  logic signed [PSUM_W-1:0] psum [LANES];
  logic signed [ACC_W-1:0] acc [LANES];
  logic signed [ACC_W-1:0] acc_in [LANES];
  logic signed [ACC_W:0] s1 [LANES];
  logic [4:0] shift1;
  logic v1, last;
  act_vec_t act;
  assign psum[0] = iPsum0;
  assign psum[1] = iPsum1;
  assign psum[2] = iPsum2;
  assign psum[3] = iPsum3;
  // iClr makes the current beat the first of a fresh group
  always_comb begin
    cnt_eff = iClr ? '0 : cnt;
    last_idx = (iNumCh == '0) ? '0 : iNumCh - 1'b1;
    last = vld_i && (cnt_eff == last_idx);
    for (int l = 0; l < LANES; l++)
      acc_in[l] = ((cnt_eff == '0) ? '0 : acc[l]) + {{(ACC_W-PSUM_W){psum[l][PSUM_W-1]}}, psum[l]};
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
      v1 <= 1'b0;
      shift1 <= '0;
      vld_o <= 1'b0;
      oOut <= '0;
      oPool <= '0;
      for (int l = 0; l < LANES; l++) begin
        acc[l] <= '0;
        s1[l] <= '0;
      end
    end else begin
      if (vld_i) begin
        cnt <= last ? '0 : cnt_eff + 1'b1;
        for (int l = 0; l < LANES; l++) acc[l] <= acc_in[l];
      end else if (iClr) begin
        cnt <= '0;
      end
      v1 <= last;
      if (last) begin
        shift1 <= iShift;
        for (int l = 0; l < LANES; l++)
          s1[l] <= {acc_in[l][ACC_W-1], acc_in[l]} + {{(ACC_W+1-BIAS_W){iBias[BIAS_W-1]}}, iBias};
      end
      vld_o <= v1;
      if (v1) begin
        oOut <= act;
        oPool <= max4(act);
      end
    end
  end
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    quant_lane #(.W(ACC_W + 1)) u_lane (.s1(s1[i]), .shift(shift1), .act(act[i]));
  end
endmodule

// File: doc/psum_quant.md
# psum_quant

Post-MAC output stage, directly downstream of the four-lane 3x3 convolution MAC. It accumulates the MAC's four 20-bit partial sums across input channels and adds a per-output-channel bias. It then applies ReLU, a rounding arithmetic right-shift and saturation to int8. The result is emitted as one 32-bit packed word of four activations, plus the 2x2 max-pool value, to the output feature-map writer.

## Interface
- ACC_W, 28: accumulator width per lane, signed; must be at least 20.
- CH_W, 8: width of the channel-count input.
- clk  in  1  single clock, rising edge.
- rstn  in  1  reset, asynchronous and active-low.
- vld_i  in  1  one partial-sum beat (one input channel) is present on iPsum0..3.
- iPsum0..iPsum3  in  20 each  signed two's-complement partial sums, lanes 0..3, from the MAC outputs oOut0..oOut3.
- iNumCh  in  CH_W  number of input channels per group; 0 is treated as 1; must be held stable for the whole group.
- iBias  in  16  signed bias, in accumulator units; sampled on the last beat of a group.
- iShift  in  5  right-shift amount, 0..31; sampled on the last beat of a group.
- iClr  in  1  synchronous abort of the current group.
- oOut  out  32  packed unsigned activations, lane n at [8n+7:8n], each 0..127.
- oPool  out  8  maximum of the four lanes in oOut.
- vld_o  out  1  one-cycle strobe; oOut and oPool are valid while it is high.

## Operation
- Channel counter cnt runs 0..N-1, where N = max(iNumCh, 1). Each lane has an accumulator acc of ACC_W bits.
- Accumulate step, on a vld_i beat:
  - if cnt==0: acc <= sext(iPsum), i.e. overwrite;
  - otherwise acc <= acc + sext(iPsum).
  - The accumulator wraps on overflow; there is no saturation inside the group.
- Last beat (vld_i && cnt==N-1):
  - cnt <= 0;
  - stage-1 register s1 <= acc_in + sext(iBias), where acc_in is the value the step would produce; s1 is ACC_W+1 bits;
  - iShift is captured into stage 1;
  - v1 <= 1.
- Stage 2, per lane, implemented in quant_lane:
  - r = (s1 < 0) ? 0 : s1 (ReLU);
  - if shift>0: q = (r + 2^(shift-1)) >>> shift (round half up); else q = r;
  - out = min(q, 127).
  - Registers oOut, oPool = max of the four lanes, and vld_o <= v1.
- iClr: cnt <= 0. An in-flight stage-1/stage-2 result is not affected.
- iClr together with vld_i: the beat is the first beat of a new group (overwrite). If N==1 it is also the last beat.
- No backpressure: the consumer must accept one result per cycle.

## Timing
- Reset values: oOut=0, oPool=0, vld_o=0, cnt=0, acc=0, v1=0.
- Latency: the last beat is sampled on edge k; oOut, oPool and vld_o update on edge k+1; vld_o is high for exactly one cycle unless the next group also completed.
- Throughput: with N=1 a result is produced every cycle while vld_i is high continuously.
- Gaps: vld_i low between beats of a group is allowed; state is held.
- Reset asserted mid-group or mid-pipeline: all state clears immediately. The partial group and any pending vld_o are discarded.
- Changing iNumCh mid-group is illegal. The bench asserts iNumCh is stable while cnt != 0.

## Structure
- Package psum_quant_pkg holds:
  - constants PSUM_W=20, BIAS_W=16, ACT_W=8, ACT_MAX=127, LANES=4;
  - a packed-lane typedef for oOut.
- Sub-module quant_lane holds the ReLU, rounding shift and saturation logic, with stage-2 registers excluded. It is instantiated four times.
- Top-level psum_quant holds cnt, the accumulators, stage 1 and stage 2.

## Test plan
- iNumCh=1, iPsum={100,-50,300,0} for lanes 0..3, iBias=0, iShift=1 -> lanes 50,0,127,0; oOut=32'h007F0032, oPool=127; vld_o on edge k+1.
- iNumCh=3, lane0 beats 10,20,30, iBias=4, iShift=2 -> 64, then (64+2)>>2 = 16; lane0=16; vld_o exactly once, one cycle after the third beat.
- iNumCh=0, iPsum=5 on all lanes, iBias=-10, iShift=0 -> all lanes 0; oPool=0; also covers N treated as 1 and the no-rounding path.
- Back-to-back: iNumCh=1 with vld_i high for 4 cycles, lane0 = 1,2,3,4, iShift=0 -> vld_o high for 4 consecutive cycles with lane0 = 1,2,3,4.
- iNumCh=4, two beats of 100 each, then iClr with vld_i and lane0=7, then 3 more beats of 1 -> one result, lane0=10; the aborted sum is not output.
- iNumCh=2, rstn pulsed low after the first beat -> outputs are 0 immediately; a following fresh 2-beat group of 3 and 4 with iShift=0 -> lane0=7.
